// File: rtl/game_controller.sv
// game_controller -- top-level game FSM for a minesweeper-style board.
//
// Tracks game state (INIT/PLAY/WIN/LOSE, one-hot), the cursor, the number of
// non-mine cells still to open, the flags left to place, and an elapsed-seconds
// timer that starts on the first opened cell.
//
// Ports
//   board_clk, glob_reset             clock, async active-high reset
//   btn_l/r/u/d, btn_c, btn_f         single-cycle debounced button pulses
//   is_init                           board generator busy when nonzero
//   num_non_mines, num_mines          board totals, valid when is_init==0
//   opened_cell, flag_set, flag_clr   status pulses from the cover
//   cell_val_apparent                 value under the cursor, 5'b11111 = mine
//   state                             one-hot INIT/PLAY/WIN/LOSE
//   x_pos, y_pos                      cursor
//   board_rst                         one-cycle board/cover regeneration pulse
//   open_out, flag_out                registered one-cycle commands to cover
//   cells_to_open, flags_left, seconds  game counters
module game_controller #(
   parameter int X_SIZE     = 16,
   parameter int Y_SIZE     = 16,
   parameter int X_BITS     = 4,
   parameter int Y_BITS     = 4,
   parameter int WRAP       = 0,
   parameter int TICK_DIV   = 50000000,
   parameter int TIMER_BITS = 10
) (
   input  logic                     board_clk,
   input  logic                     glob_reset,
   input  logic                     btn_l,
   input  logic                     btn_r,
   input  logic                     btn_u,
   input  logic                     btn_d,
   input  logic                     btn_c,
   input  logic                     btn_f,
   input  logic [1:0]               is_init,
   input  logic [X_BITS+Y_BITS:0]   num_non_mines,
   input  logic [X_BITS+Y_BITS:0]   num_mines,
   input  logic                     opened_cell,
   input  logic                     flag_set,
   input  logic                     flag_clr,
   input  logic [4:0]               cell_val_apparent,
   output logic [3:0]               state,
   output logic [X_BITS-1:0]        x_pos,
   output logic [Y_BITS-1:0]        y_pos,
   output logic                     board_rst,
   output logic                     open_out,
   output logic                     flag_out,
   output logic [X_BITS+Y_BITS:0]   cells_to_open,
   output logic [X_BITS+Y_BITS:0]   flags_left,
   output logic [TIMER_BITS-1:0]    seconds
);

   localparam int C         = X_BITS + Y_BITS + 1;
   localparam int TICK_BITS = $clog2(TICK_DIV);

   localparam logic [3:0] S_INIT = 4'b0001;
   localparam logic [3:0] S_PLAY = 4'b0010;
   localparam logic [3:0] S_WIN  = 4'b0100;
   localparam logic [3:0] S_LOSE = 4'b1000;

   localparam logic [4:0]            MINE     = 5'b11111;
   localparam logic [X_BITS:0]       X_MAX    = (X_BITS+1)'(X_SIZE - 1);
   localparam logic [Y_BITS:0]       Y_MAX    = (Y_BITS+1)'(Y_SIZE - 1);
   localparam logic [X_BITS-1:0]     X_ONE    = X_BITS'(1);
   localparam logic [Y_BITS-1:0]     Y_ONE    = Y_BITS'(1);
   localparam logic [C-1:0]          C_ONE    = C'(1);
   localparam logic [TIMER_BITS-1:0] SEC_ONE  = TIMER_BITS'(1);
   localparam logic [TICK_BITS-1:0]  TICK_ONE = TICK_BITS'(1);
   localparam logic [TICK_BITS-1:0]  TICK_MAX = TICK_BITS'(TICK_DIV - 1);

   logic [TICK_BITS-1:0] tick_cnt;
   logic                 started;
   logic                 hit_mine;
   logic [X_BITS:0]      x_ext;
   logic [Y_BITS:0]      y_ext;
   logic [X_BITS-1:0]    x_nxt;
   logic [Y_BITS-1:0]    y_nxt;

   assign hit_mine = (cell_val_apparent == MINE);

   // Edge tests run one bit wider than the coordinate so a board that fills
   // the whole coordinate range still compares correctly against SIZE-1.
   always_comb begin
      x_ext = {1'b0, x_pos};
      x_nxt = x_pos;
      if (btn_l && !btn_r) begin
         if (x_ext == '0)
            x_nxt = (WRAP != 0) ? X_MAX[X_BITS-1:0] : x_pos;
         else
            x_nxt = x_pos - X_ONE;
      end else if (btn_r && !btn_l) begin
         if (x_ext == X_MAX)
            x_nxt = (WRAP != 0) ? '0 : x_pos;
         else
            x_nxt = x_pos + X_ONE;
      end
   end

   always_comb begin
      y_ext = {1'b0, y_pos};
      y_nxt = y_pos;
      if (btn_u && !btn_d) begin
         if (y_ext == '0)
            y_nxt = (WRAP != 0) ? Y_MAX[Y_BITS-1:0] : y_pos;
         else
            y_nxt = y_pos - Y_ONE;
      end else if (btn_d && !btn_u) begin
         if (y_ext == Y_MAX)
            y_nxt = (WRAP != 0) ? '0 : y_pos;
         else
            y_nxt = y_pos + Y_ONE;
      end
   end

   always_ff @(posedge board_clk or posedge glob_reset) begin
      if (glob_reset) begin
         state         <= S_INIT;
         x_pos         <= '0;
         y_pos         <= '0;
         board_rst     <= 1'b0;
         open_out      <= 1'b0;
         flag_out      <= 1'b0;
         cells_to_open <= '0;
         flags_left    <= '0;
         seconds       <= '0;
         tick_cnt      <= '0;
         started       <= 1'b0;
      end else begin
         board_rst <= 1'b0;
         open_out  <= 1'b0;
         flag_out  <= 1'b0;
         case (state)
            // Hold off while the regeneration pulse is still out, so the
            // generator gets a chance to raise is_init before we sample it.
            S_INIT: begin
               if (is_init == 2'b00 && !board_rst) begin
                  state         <= S_PLAY;
                  cells_to_open <= num_non_mines;
                  flags_left    <= num_mines;
                  seconds       <= '0;
                  tick_cnt      <= '0;
                  started       <= 1'b0;
               end
            end
            S_PLAY: begin
               open_out <= btn_c;
               flag_out <= btn_f;
               x_pos    <= x_nxt;
               y_pos    <= y_nxt;
               if (hit_mine)
                  state <= S_LOSE;
               else if (cells_to_open == '0)
                  state <= S_WIN;
               if (opened_cell && !hit_mine && cells_to_open != '0)
                  cells_to_open <= cells_to_open - C_ONE;
               if (flag_set && !flag_clr) begin
                  if (flags_left != '0)
                     flags_left <= flags_left - C_ONE;
               end else if (flag_clr && !flag_set) begin
                  if (flags_left < num_mines)
                     flags_left <= flags_left + C_ONE;
               end
               if (opened_cell)
                  started <= 1'b1;
               if (started) begin
                  if (tick_cnt == TICK_MAX) begin
                     tick_cnt <= '0;
                     if (seconds != '1)
                        seconds <= seconds + SEC_ONE;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_ONE;
                  end
               end
            end
            S_WIN, S_LOSE: begin
               if (btn_c) begin
                  state     <= S_INIT;
                  board_rst <= 1'b1;
                  x_pos     <= '0;
                  y_pos     <= '0;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule
